snn_ofmap_accum: RTL

Clocked, parametrised output-feature-map neuron stage for the SNN datapath. It accepts partial-sum packets (row, col, value) from the PE array and keeps a per-neuron residue (membrane potential) across NUM_TS timesteps. Each packet is threshold-compared and produces one spike record (linear address, spike bit) toward the next layer. Sequencing is start/done, with ts_idx reporting the current timestep.

---
 rtl/snn_pkg.sv | 34 +++
 rtl/snn_ofmap_accum_if.sv | 32 +++
 rtl/snn_residue_ram.sv | 43 ++++
 rtl/snn_ofmap_accum.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types for the SNN ofmap neuron stage: packet/record structs, FSM states
// and the saturating add used for residue accumulation.
package snn_pkg;

   localparam int unsigned PKT_PSUM_W = 16;
   localparam int unsigned REC_ADDR_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   typedef struct packed {
      logic [4:0]            row;
      logic [4:0]            col;
      logic [PKT_PSUM_W-1:0] psum;
   } psum_pkt_t;

   typedef struct packed {
      logic [REC_ADDR_W-1:0] addr;
      logic                  spike;
   } spike_rec_t;

   // a + b clamped to 2^w-1 (w < 32)
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned w);
      logic [31:0] m;
      m = (32'd1 << w) - 32'd1;
      if (b > m || a > m - b) return m;
      return a + b;
   endfunction

endpackage

// File: rtl/snn_ofmap_accum_if.sv
// Handshake/bus bundle of the ofmap neuron stage; master drives packets and
// consumes spike records, slave is the neuron stage.
interface snn_ofmap_accum_if #(
   parameter int unsigned PSUM_W = 13,
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned TS_W   = 2
);
   logic              start;
   logic              busy;
   logic              done;
   logic [TS_W-1:0]   ts_idx;
   logic              in_valid;
   logic              in_ready;
   logic [4:0]        in_row;
   logic [4:0]        in_col;
   logic [PSUM_W-1:0] in_psum;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_addr;
   logic              out_spike;
   logic              err_addr;

   modport master (
      output start, in_valid, in_row, in_col, in_psum, out_ready,
      input  busy, done, ts_idx, in_ready, out_valid, out_addr, out_spike, err_addr
   );

   modport slave (
      input  start, in_valid, in_row, in_col, in_psum, out_ready,
      output busy, done, ts_idx, in_ready, out_valid, out_addr, out_spike, err_addr
   );
endinterface

// File: rtl/snn_residue_ram.sv
// Per-neuron residue store: async-read register array whose writes land one
// cycle late through a write buffer; reads bypass the buffered write.
module snn_residue_ram #(
   parameter int unsigned DEPTH = 441,
   parameter int unsigned AW    = 9,
   parameter int unsigned DW    = 14
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] rd_addr_i,
   output logic [DW-1:0] rd_data_o,
   input  logic          we_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [DW-1:0] wr_data_i
);

   logic [DW-1:0] mem_q [DEPTH];
   logic          wb_vld_q;
   logic [AW-1:0] wb_addr_q;
   logic [DW-1:0] wb_data_q;

   always_ff @(posedge clk) begin
      if (!rst_n) wb_vld_q <= 1'b0;
      else        wb_vld_q <= we_i;
   end

   always_ff @(posedge clk) begin
      wb_addr_q <= wr_addr_i;
      wb_data_q <= wr_data_i;
   end

   always_ff @(posedge clk) begin
      if (wb_vld_q) mem_q[wb_addr_q] <= wb_data_q;
   end

   // Back-to-back updates of one neuron must see the value still in the buffer
   always_comb begin
      rd_data_o = '0;
      if (wb_vld_q && wb_addr_q == rd_addr_i) rd_data_o = wb_data_q;
      else if (32'(rd_addr_i) < DEPTH)        rd_data_o = mem_q[rd_addr_i];
   end

endmodule

// File: rtl/snn_ofmap_accum.sv
// Ofmap neuron stage: accumulates partial sums into per-neuron residues over
// NUM_TS timesteps and emits one spike record per packet.
// Build option: SNN_OFMAP_SPARSE_OUT_EN emits only spike=1 records.
module snn_ofmap_accum
   import snn_pkg::*;
#(
   parameter int unsigned ROWS      = 21,
   parameter int unsigned COLS      = 21,
   parameter int unsigned PSUM_W    = 13,
   parameter int unsigned RES_W     = 14,
   parameter int unsigned THRESHOLD = 64,
   parameter int unsigned NUM_TS    = 2,
   parameter int unsigned ADDR_W    = $clog2(ROWS*COLS)
) (
   input  logic             clk,
   input  logic             rst_n,
   snn_ofmap_accum_if.slave bus
);

   localparam int unsigned NEUR = ROWS * COLS;
   localparam int unsigned TS_W = $clog2(NUM_TS + 1);

   state_e            state_q, state_d;
   logic [TS_W-1:0]   ts_q, ts_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic              out_vld_q, out_vld_d;
   spike_rec_t        rec_q, rec_d;

   psum_pkt_t         pkt;
   logic              in_range, in_ready, accept, emit, spike;
   logic [ADDR_W-1:0] addr;
   logic [RES_W-1:0]  res_rd, res_wr;
   logic [31:0]       r;
   logic              unused_addr_hi;

   assign pkt      = '{row: bus.in_row, col: bus.in_col,
                       psum: PKT_PSUM_W'(PSUM_W'(bus.in_psum))};
   assign in_range = (32'(pkt.row) < ROWS) && (32'(pkt.col) < COLS);
   assign addr     = ADDR_W'(32'(pkt.row) * COLS + 32'(pkt.col));
   assign in_ready = (state_q == ST_RUN) && (!out_vld_q || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   // Timestep 1 overwrites the residue, so the RAM never needs clearing
   assign r      = (ts_q == TS_W'(1)) ? sat_add(32'(pkt.psum), 32'd0, RES_W)
                                      : sat_add(32'(res_rd), 32'(pkt.psum), RES_W);
   assign spike  = r > THRESHOLD;
   assign res_wr = spike ? RES_W'(r - THRESHOLD) : RES_W'(r);

`ifdef SNN_OFMAP_SPARSE_OUT_EN
   assign emit = accept && in_range && spike;
`else
   assign emit = accept && in_range;
`endif

   snn_residue_ram #(.DEPTH(NEUR), .AW(ADDR_W), .DW(RES_W)) u_res (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr_i (addr),
      .rd_data_o (res_rd),
      .we_i      (accept && in_range),
      .wr_addr_i (addr),
      .wr_data_i (res_wr)
   );

   always_comb begin
      state_d   = state_q;
      ts_d      = ts_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      done_d    = 1'b0;
      out_vld_d = out_vld_q;
      rec_d     = rec_q;
      if (bus.out_ready) out_vld_d = 1'b0;
      if (emit) begin
         out_vld_d  = 1'b1;
         rec_d.addr = REC_ADDR_W'(addr);
         rec_d.spike = spike;
      end
      if (accept && !in_range) err_d = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_RUN;
               ts_d    = TS_W'(1);
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         ST_RUN: begin
            if (accept) begin
               if (cnt_q == ADDR_W'(NEUR - 1)) begin
                  cnt_d = '0;
                  if (ts_q == TS_W'(NUM_TS)) state_d = ST_DRAIN;
                  else                       ts_d    = ts_q + TS_W'(1);
               end else begin
                  cnt_d = cnt_q + ADDR_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (!out_vld_q || bus.out_ready) begin
               state_d = ST_IDLE;
               ts_d    = '0;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ts_q      <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         out_vld_q <= 1'b0;
         rec_q     <= '0;
      end else begin
         state_q   <= state_d;
         ts_q      <= ts_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         done_q    <= done_d;
         out_vld_q <= out_vld_d;
         rec_q     <= rec_d;
      end
   end

   assign unused_addr_hi = |(rec_q.addr >> ADDR_W);

   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.done      = done_q;
   assign bus.ts_idx    = ts_q;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_vld_q;
   assign bus.out_addr  = ADDR_W'(rec_q.addr);
   assign bus.out_spike = rec_q.spike;
   assign bus.err_addr  = err_q;

endmodule
